// File: rtl/imem_prefetch_buffer_pkg.sv
// Shared types for the instruction prefetch buffer: FSM states and FIFO entry layout.
// No logic, so no latency.
// No flow control lives here.
package imem_prefetch_buffer_pkg;

  localparam int PF_XLEN = 32;

  typedef enum logic [1:0] {
    PF_IDLE  = 2'd0,
    PF_BUSY  = 2'd1,
    PF_STALE = 2'd2
  } pf_state_e;

  typedef struct packed {
    logic [PF_XLEN-1:0] addr;
    logic [PF_XLEN-1:0] data;
  } pf_entry_t;

  // Word-granular address compare; byte offset bits are ignored.
  function automatic logic word_match(input logic [PF_XLEN-1:0] a,
                                      input logic [PF_XLEN-1:0] b);
    return a[PF_XLEN-1:2] == b[PF_XLEN-1:2];
  endfunction

endpackage

// File: rtl/imem_prefetch_buffer_fifo.sv
// Circular FIFO of {addr,data} prefetch entries with push/pop/clear and a head read port.
// Latency: a push is visible at the head on the next cycle; the head read is combinational.
// Backpressure: none; the caller must never push when full (clear beats push and pop).
module imem_prefetch_buffer_fifo
  import imem_prefetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_clear,
  input  pf_entry_t                  i_wr_entry,
  output pf_entry_t                  o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  pf_entry_t         r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  // Entry storage; a clear in the same cycle discards the write.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_wr_entry;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/imem_prefetch_buffer.sv
// Sequential instruction prefetcher between the CPU fetch port and a word-wide memory.
// Latency: FIFO hits are served combinationally; misses cost one cycle plus memory latency.
// Backpressure: only one memory request is outstanding; prefetching stops while the FIFO is full.
module imem_prefetch_buffer
  import imem_prefetch_buffer_pkg::*;
#(
  parameter int              XLEN       = PF_XLEN,
  parameter int              DEPTH      = 4,
  parameter logic [XLEN-1:0] RESET_ADDR = '0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [XLEN-1:0]            i_cpu_addr,
  input  logic                       i_cpu_req,
  output logic [XLEN-1:0]            o_cpu_rdata,
  output logic                       o_cpu_ready,
  input  logic                       i_flush,
  output logic [XLEN-1:0]            o_mem_addr,
  output logic                       o_mem_req,
  input  logic [XLEN-1:0]            i_mem_rdata,
  input  logic                       i_mem_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_fifo_count
);

  localparam int              CW       = $clog2(DEPTH+1);
  localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
  localparam logic [CW:0]     DEPTH_X  = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] WORD_INC = XLEN'(4);

  pf_state_e       r_state;
  logic [XLEN-1:0] r_next_addr;
  logic [XLEN-1:0] r_req_addr;

  pf_entry_t       w_head;
  pf_entry_t       w_wr_entry;
  logic [CW-1:0]   w_count;
  logic [CW:0]     w_count_after;
  logic [XLEN-1:0] w_cpu_word;
  logic            w_empty, w_busy, w_live, w_req_match;
  logic            w_hit, w_bypass, w_pending, w_miss;
  logic            w_push, w_pop, w_clear;

  // A flush suppresses every CPU-side outcome for that cycle.
  assign w_live      = i_cpu_req && !i_flush;
  assign w_empty     = (w_count == '0);
  assign w_busy      = (r_state == PF_BUSY);
  assign w_cpu_word  = i_cpu_addr & ~XLEN'(3);
  assign w_req_match = word_match(r_req_addr, i_cpu_addr);

  assign w_hit     = w_live && !w_empty && word_match(w_head.addr, i_cpu_addr);
  assign w_bypass  = w_live && w_empty && w_busy && i_mem_ready && w_req_match;
  assign w_pending = w_live && w_empty && w_busy && !i_mem_ready && w_req_match;
  assign w_miss    = w_live && !w_hit && !w_bypass && !w_pending;

  // Bypassed words go straight to the CPU; a miss or flush drops this cycle's response.
  assign w_push  = w_busy && i_mem_ready && !w_bypass && !w_miss && !i_flush;
  assign w_pop   = w_hit;
  assign w_clear = w_miss || i_flush;

  assign w_count_after = {1'b0, w_count} + {{CW{1'b0}}, w_push} - {{CW{1'b0}}, w_pop};
  assign w_wr_entry    = '{addr: r_req_addr, data: i_mem_rdata};

  imem_prefetch_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_clear    (w_clear),
    .i_wr_entry (w_wr_entry),
    .o_head     (w_head),
    .o_count    (w_count)
  );

  // Request FSM: issue, chain sequential prefetches, and retire stale responses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= PF_IDLE;
      r_next_addr <= RESET_ADDR;
      r_req_addr  <= RESET_ADDR;
    end else begin
      case (r_state)
        PF_IDLE: begin
          if (w_miss) begin
            r_req_addr  <= w_cpu_word;
            r_next_addr <= w_cpu_word + WORD_INC;
            r_state     <= PF_BUSY;
          end else if (w_count < DEPTH_C) begin
            r_req_addr  <= r_next_addr;
            r_next_addr <= r_next_addr + WORD_INC;
            r_state     <= PF_BUSY;
          end
        end
        PF_BUSY: begin
          if (i_flush || w_miss) begin
            r_state <= PF_STALE;
            if (w_miss) r_next_addr <= w_cpu_word;
          end else if (i_mem_ready) begin
            if (w_count_after < DEPTH_X) begin
              r_req_addr  <= r_next_addr;
              r_next_addr <= r_next_addr + WORD_INC;
            end else begin
              r_state <= PF_IDLE;
            end
          end
        end
        PF_STALE: begin
          if (w_miss)      r_next_addr <= w_cpu_word;
          if (i_mem_ready) r_state     <= PF_IDLE;
        end
        default: r_state <= PF_IDLE;
      endcase
    end
  end

  assign o_mem_req    = (r_state != PF_IDLE);
  assign o_mem_addr   = r_req_addr;
  assign o_cpu_ready  = w_hit || w_bypass;
  assign o_cpu_rdata  = w_hit ? w_head.data : (w_bypass ? i_mem_rdata : '0);
  assign o_fifo_count = w_count;

endmodule

// File: tb/tb_imem_prefetch_buffer.sv
// Self-checking bench: queue-based reference model of the prefetcher plus a waiting memory.
// One step per clock: inputs driven after the edge, outputs checked at the falling edge.
// Directed scenarios first, then a long randomized run with random waits, branches and flushes.
module tb_imem_prefetch_buffer;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_A  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_cpu_addr;
  logic        i_cpu_req;
  logic [31:0] o_cpu_rdata;
  logic        o_cpu_ready;
  logic        i_flush;
  logic [31:0] o_mem_addr;
  logic        o_mem_req;
  logic [31:0] i_mem_rdata;
  logic        i_mem_ready;
  logic [2:0]  o_fifo_count;

  always #5 clk = ~clk;

  imem_prefetch_buffer #(.XLEN(32), .DEPTH(DEPTH), .RESET_ADDR(RST_A)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_cpu_addr   (i_cpu_addr),
    .i_cpu_req    (i_cpu_req),
    .o_cpu_rdata  (o_cpu_rdata),
    .o_cpu_ready  (o_cpu_ready),
    .i_flush      (i_flush),
    .o_mem_addr   (o_mem_addr),
    .o_mem_req    (o_mem_req),
    .i_mem_rdata  (i_mem_rdata),
    .i_mem_ready  (i_mem_ready),
    .o_fifo_count (o_fifo_count)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // stimulus knobs
  logic        creq = 1'b0;
  logic [31:0] caddr = '0;
  logic        fl = 1'b0;
  logic        rand_waits = 1'b0;
  int          fixed_wait = 0;

  // memory model
  int mw_cnt = 0;
  int mw_tgt = 0;

  // reference model: FIFO contents as queues, one outstanding request
  logic [31:0] qa[$];
  logic [31:0] qd[$];
  logic        m_busy, m_stale;
  logic [31:0] m_req, m_next;

  // last observed outputs
  logic [31:0] obs_rdy, obs_dat, obs_cnt, obs_mreq, obs_maddr;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'h5A5A_A5A5;
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    qa.delete(); qd.delete();
    m_busy = 1'b0; m_stale = 1'b0;
    m_req = RST_A; m_next = RST_A;
  endtask

  task automatic issue(input logic [31:0] a);
    m_req  = align(a);
    m_next = align(a) + 32'd4;
    m_busy = 1'b1;
  endtask

  // One clock: drive, check at negedge, advance model, return at posedge+1.
  task automatic step();
    logic        mr, hit, byp, pend, miss, live, e_rdy;
    logic [31:0] md, e_dat;
    int          cnt;
    mr = o_mem_req && (mw_cnt >= mw_tgt);
    md = mr ? memf(o_mem_addr) : $urandom();
    i_cpu_req   = creq;
    i_cpu_addr  = caddr;
    i_flush     = fl;
    i_mem_ready = mr;
    i_mem_rdata = md;
    @(negedge clk);
    cnt  = qa.size();
    live = m_busy && !m_stale;
    hit  = creq && !fl && cnt > 0 && qa[0][31:2] == caddr[31:2];
    byp  = creq && !fl && cnt == 0 && live && mr && m_req[31:2] == caddr[31:2];
    pend = creq && !fl && cnt == 0 && live && !mr && m_req[31:2] == caddr[31:2];
    miss = creq && !fl && !hit && !byp && !pend;
    e_rdy = hit || byp;
    e_dat = hit ? qd[0] : (byp ? md : 32'h0);
    obs_rdy   = {31'b0, o_cpu_ready};
    obs_dat   = o_cpu_rdata;
    obs_cnt   = {29'b0, o_fifo_count};
    obs_mreq  = {31'b0, o_mem_req};
    obs_maddr = o_mem_addr;
    chk("cpu_ready",  obs_rdy,   {31'b0, e_rdy});
    chk("cpu_rdata",  obs_dat,   e_dat);
    chk("mem_req",    obs_mreq,  {31'b0, m_busy});
    chk("mem_addr",   obs_maddr, m_req);
    chk("fifo_count", obs_cnt,   cnt);
    // advance FIFO contents
    if (fl || miss) begin
      qa.delete(); qd.delete();
    end else begin
      if (hit) begin void'(qa.pop_front()); void'(qd.pop_front()); end
      if (live && mr && !byp) begin qa.push_back(m_req); qd.push_back(md); end
    end
    // advance request tracking
    if (!m_busy) begin
      if (miss) issue(caddr);
      else if (cnt < DEPTH) issue(m_next);
    end else if (!m_stale) begin
      if (fl || miss) begin
        m_stale = 1'b1;
        if (miss) m_next = align(caddr);
      end else if (mr) begin
        if (qa.size() < DEPTH) issue(m_next);
        else m_busy = 1'b0;
      end
    end else begin
      if (miss) m_next = align(caddr);
      if (mr) begin m_busy = 1'b0; m_stale = 1'b0; end
    end
    // memory wait-state bookkeeping
    if (o_mem_req && mr) begin
      mw_cnt = 0;
      mw_tgt = rand_waits ? int'($urandom_range(0, 3)) : fixed_wait;
    end else if (o_mem_req) begin
      mw_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    model_reset();
    mw_cnt = 0;
    mw_tgt = rand_waits ? int'($urandom_range(0, 3)) : fixed_wait;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    creq = 1'b0; caddr = '0; fl = 1'b0;
    i_cpu_req = 1'b0; i_cpu_addr = '0; i_flush = 1'b0;
    i_mem_ready = 1'b0; i_mem_rdata = '0;
    @(posedge clk);
    #1;
    chk("rst_mem_req",   {31'b0, o_mem_req},   32'd0);
    chk("rst_mem_addr",  o_mem_addr,           RST_A);
    chk("rst_cpu_ready", {31'b0, o_cpu_ready}, 32'd0);
    chk("rst_cpu_rdata", o_cpu_rdata,          32'd0);
    chk("rst_count",     {29'b0, o_fifo_count}, 32'd0);
    release_reset();
  endtask

  initial begin
    logic [31:0] pc;
    logic        found, got;
    int          r;

    // 1: sequential run with zero-wait memory
    fixed_wait = 0;
    do_reset();
    creq = 1'b1; caddr = 32'h0;
    step();
    chk("t1_cycle0_ready", obs_rdy, 32'd0);
    step();
    chk("t1_cycle1_bypass", obs_rdy, 32'd1);
    chk("t1_cycle1_data",   obs_dat, memf(32'h0));
    for (int a = 4; a <= 12; a += 4) begin
      caddr = a;
      step();
      chk("t1_stream_ready", obs_rdy, 32'd1);
    end
    creq = 1'b0;
    repeat (8) step();
    chk("t1_fill_count", obs_cnt, DEPTH);
    chk("t1_fill_noreq", obs_mreq, 32'd0);

    // 2: branch with the FIFO holding 0x10..0x1C
    creq = 1'b1; caddr = 32'h100;
    step();
    chk("t2_miss_ready", obs_rdy, 32'd0);
    step();
    chk("t2_redirect_addr", obs_maddr, 32'h100);
    chk("t2_cleared",       obs_cnt,   32'd0);
    chk("t2_target_data",   obs_dat,   memf(32'h100));
    for (int a = 32'h104; a <= 32'h110; a += 4) begin
      caddr = a;
      step();
      chk("t2_stream_data", obs_dat, memf(a));
    end

    // 3: stale drop with 3-wait memory
    fixed_wait = 3;
    do_reset();
    pc = 32'h0; found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      creq = 1'b1; caddr = pc;
      step();
      if (obs_rdy[0]) pc += 4;
      if (o_mem_req && o_mem_addr == 32'h20) found = 1'b1;
    end
    chk("t3_reach_0x20", {31'b0, found}, 32'd1);
    caddr = 32'h80;
    step();
    chk("t3_miss_ready", obs_rdy, 32'd0);
    step();
    chk("t3_cleared", obs_cnt, 32'd0);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      step();
      if (obs_rdy[0]) begin
        got = 1'b1;
        chk("t3_target_data", obs_dat, memf(32'h80));
      end
    end
    chk("t3_served", {31'b0, got}, 32'd1);

    // 4: push and pop together at DEPTH-1
    fixed_wait = 0;
    do_reset();
    repeat (6) step();
    chk("t4_full", obs_cnt, DEPTH);
    creq = 1'b1; caddr = 32'h0;
    step();
    creq = 1'b0;
    step();
    chk("t4_depth_minus1", obs_cnt, DEPTH - 1);
    creq = 1'b1;
    for (int a = 4; a <= 32'h20; a += 4) begin
      caddr = a;
      step();
      chk("t4_steady_count", obs_cnt, DEPTH - 1);
      chk("t4_order_data",   obs_dat, memf(a));
    end
    creq = 1'b0;
    repeat (3) step();
    chk("t4_refill", obs_cnt, DEPTH);
    chk("t4_req_drop", obs_mreq, 32'd0);

    // 5: flush while a request is in flight
    fixed_wait = 2;
    do_reset();
    step();
    step();
    chk("t5_busy", obs_mreq, 32'd1);
    fl = 1'b1;
    step();
    fl = 1'b0;
    step();
    chk("t5_cleared", obs_cnt, 32'd0);
    repeat (20) step();
    chk("t5_refill", obs_cnt, DEPTH);
    creq = 1'b1; caddr = 32'h4;
    step();
    chk("t5_resume_ready", obs_rdy, 32'd1);
    chk("t5_resume_data",  obs_dat, memf(32'h4));

    // 6: asynchronous reset mid-transfer, off the clock edge
    fixed_wait = 3;
    do_reset();
    creq = 1'b0;
    repeat (6) step();
    #2;
    i_rst = 1'b1;
    #1;
    chk("t6_async_req",  {31'b0, o_mem_req}, 32'd0);
    chk("t6_async_addr", o_mem_addr,         RST_A);
    chk("t6_async_cnt",  {29'b0, o_fifo_count}, 32'd0);
    release_reset();
    step();
    step();
    chk("t6_first_req",  obs_mreq,  32'd1);
    chk("t6_first_addr", obs_maddr, RST_A);

    // randomized traffic
    rand_waits = 1'b1;
    do_reset();
    pc = 32'h0;
    for (int k = 0; k < 4000; k++) begin
      if (creq && obs_rdy[0]) pc += 4;
      r = int'($urandom_range(0, 99));
      if (r < 4)       pc = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
      else if (r == 4) pc = 32'hFFFF_FFF4;
      fl    = ($urandom_range(0, 99) < 2);
      creq  = ($urandom_range(0, 3) != 0);
      caddr = pc;
      step();
    end
    creq = 1'b0; fl = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
